// File: rtl/euler_integrator_bank.sv
// euler_integrator_bank
//   Multi-channel, time-multiplexed forward-Euler integrator.
//   Each channel computes x_k(n+1) = x_k(n) + (f_k >>> dt). A step request
//   walks the channels one per cycle through a single shared adder/saturator.
//   The derivative of channel func_sel is read from func_in in the same
//   cycle. Results are collected in shadow registers and committed together,
//   so every derivative is evaluated on state n.
//
// Ports
//   clock      : system clock, rising edge
//   reset      : synchronous, active-high reset
//   dt         : step size as an arithmetic right-shift count, latched on step accept
//   init_en    : load all states from init_flat (IDLE only), clears sat_flag
//   init_flat  : initial values, channel k at [k*WIDTH +: WIDTH]
//   step       : request one Euler step of all channels
//   func_in    : derivative of the channel addressed by func_sel
//   func_sel   : channel whose derivative is currently required
//   x_flat     : committed state, same packing as init_flat
//   busy       : step in progress
//   done       : one-cycle pulse when a new state is committed
//   sat_flag   : sticky overflow indicator (saturated or wrapped)
module euler_integrator_bank #(
   parameter int WIDTH    = 18,
   parameter int CHANNELS = 3,
   parameter int DT_W     = 4,
   parameter int SAT      = 1,
   parameter int SEL_W    = 2
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [DT_W-1:0]            dt,
   input  logic                       init_en,
   input  logic [CHANNELS*WIDTH-1:0]  init_flat,
   input  logic                       step,
   input  logic signed [WIDTH-1:0]    func_in,
   output logic [SEL_W-1:0]           func_sel,
   output logic [CHANNELS*WIDTH-1:0]  x_flat,
   output logic                       busy,
   output logic                       done,
   output logic                       sat_flag
);

   typedef enum logic [1:0] {IDLE, ACCUM, COMMIT} state_t;

   state_t                  state, state_nx;
   logic [SEL_W-1:0]        cnt;
   logic [DT_W-1:0]         dt_r;
   logic signed [WIDTH-1:0] x_r    [CHANNELS];
   logic signed [WIDTH-1:0] shadow [CHANNELS];

   logic signed [WIDTH-1:0] x_sel;
   logic signed [WIDTH-1:0] inc;
   logic        [WIDTH:0]   sum;
   logic                    ovf;
   logic signed [WIDTH-1:0] upd;
   logic                    last_ch;

   assign last_ch = (cnt == SEL_W'(CHANNELS-1));

   // next-state and select output
   always_comb begin
      state_nx = state;
      func_sel = '0;
      case (state)
         IDLE:    if (!init_en && step) state_nx = ACCUM;
         ACCUM: begin
            func_sel = cnt;
            if (last_ch) state_nx = COMMIT;
         end
         COMMIT:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // shared adder / saturator; sum carries one guard bit so overflow is
   // visible as a mismatch between the two top bits
   always_comb begin
      x_sel = x_r[cnt];
      inc   = func_in >>> dt_r;
      sum   = {x_sel[WIDTH-1], x_sel} + {inc[WIDTH-1], inc};
      ovf   = sum[WIDTH] ^ sum[WIDTH-1];
      upd   = sum[WIDTH-1:0];
      if (ovf && (SAT != 0)) begin
         if (sum[WIDTH]) upd = {1'b1, {(WIDTH-1){1'b0}}};
         else            upd = {1'b0, {(WIDTH-1){1'b1}}};
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         dt_r     <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         sat_flag <= 1'b0;
         for (int unsigned k = 0; k < CHANNELS; k++) begin
            x_r[k]    <= '0;
            shadow[k] <= '0;
         end
      end else begin
         state <= state_nx;
         done  <= 1'b0;
         case (state)
            IDLE: begin
               if (init_en) begin
                  sat_flag <= 1'b0;
                  for (int unsigned k = 0; k < CHANNELS; k++)
                     x_r[k] <= init_flat[k*WIDTH +: WIDTH];
               end else if (step) begin
                  dt_r <= dt;
                  cnt  <= '0;
                  busy <= 1'b1;
               end
            end
            ACCUM: begin
               shadow[cnt] <= upd;
               if (ovf) sat_flag <= 1'b1;
               cnt <= cnt + 1'b1;
            end
            COMMIT: begin
               for (int unsigned k = 0; k < CHANNELS; k++)
                  x_r[k] <= shadow[k];
               done <= 1'b1;
               busy <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      x_flat = '0;
      for (int unsigned k = 0; k < CHANNELS; k++)
         x_flat[k*WIDTH +: WIDTH] = x_r[k];
   end

endmodule

// File: tb/tb_euler_integrator_bank.sv
// tb_euler_integrator_bank
//   Two instances share all inputs: dut_a saturates (SAT=1), dut_b wraps (SAT=0).
//   Each instance gets its own derivative source, selected by 'mode':
//     0 = fixed table per channel (5120, -2048, 512)
//     1 = x0 of that instance for every channel
//     2 = constant 4096
module tb_euler_integrator_bank;
   localparam int W = 18;
   localparam int C = 3;

   logic            clock = 1'b0;
   logic            reset, init_en, step;
   logic [3:0]      dt;
   logic [C*W-1:0]  init_flat;
   logic signed [W-1:0] func_a, func_b;
   logic [1:0]      sel_a, sel_b;
   logic [C*W-1:0]  x_a, x_b;
   logic            busy_a, busy_b, done_a, done_b, sat_a, sat_b;
   int              mode;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   euler_integrator_bank #(.WIDTH(W), .CHANNELS(C), .DT_W(4), .SAT(1), .SEL_W(2)) dut_a (
      .clock(clock), .reset(reset), .dt(dt), .init_en(init_en), .init_flat(init_flat),
      .step(step), .func_in(func_a), .func_sel(sel_a), .x_flat(x_a),
      .busy(busy_a), .done(done_a), .sat_flag(sat_a));

   euler_integrator_bank #(.WIDTH(W), .CHANNELS(C), .DT_W(4), .SAT(0), .SEL_W(2)) dut_b (
      .clock(clock), .reset(reset), .dt(dt), .init_en(init_en), .init_flat(init_flat),
      .step(step), .func_in(func_b), .func_sel(sel_b), .x_flat(x_b),
      .busy(busy_b), .done(done_b), .sat_flag(sat_b));

   function automatic logic signed [W-1:0] deriv(input int m, input logic [1:0] s,
                                                  input logic signed [W-1:0] x0);
      logic signed [W-1:0] r;
      r = '0;
      case (m)
         0: case (s)
               2'd0: r = 18'sd5120;
               2'd1: r = -18'sd2048;
               2'd2: r = 18'sd512;
               default: r = '0;
            endcase
         1: r = x0;
         2: r = 18'sd4096;
         default: r = '0;
      endcase
      return r;
   endfunction

   always_comb func_a = deriv(mode, sel_a, x_a[W-1:0]);
   always_comb func_b = deriv(mode, sel_b, x_b[W-1:0]);

   function automatic int xs(input logic [C*W-1:0] v, input int k);
      logic signed [W-1:0] t;
      t = v[k*W +: W];
      return int'(t);
   endfunction

   function automatic logic [C*W-1:0] pack(input int a0, input int a1, input int a2);
      logic [C*W-1:0] p;
      p = '0;
      p[0*W +: W] = a0[W-1:0];
      p[1*W +: W] = a1[W-1:0];
      p[2*W +: W] = a2[W-1:0];
      return p;
   endfunction

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk_x(input string nm, input int a0, input int a1, input int a2,
                        input int b0, input int b1, input int b2);
      chk({nm, " a.x0"}, xs(x_a, 0), a0);
      chk({nm, " a.x1"}, xs(x_a, 1), a1);
      chk({nm, " a.x2"}, xs(x_a, 2), a2);
      chk({nm, " b.x0"}, xs(x_b, 0), b0);
      chk({nm, " b.x1"}, xs(x_b, 1), b1);
      chk({nm, " b.x2"}, xs(x_b, 2), b2);
   endtask

   typedef struct {
      int x0, x1, x2;
      int dtv;
      int m;
      int ea0, ea1, ea2;
      int eb0, eb1, eb2;
      bit esat_a, esat_b;
   } vec_t;

   vec_t vecs [6];

   initial begin
      int dones, d_first, d_second;

      // dt=9 table; isolation (all channels add old x0); dt=0 table;
      // dt=15 shift floor; positive clamp / wrap; negative clamp / wrap
      vecs[0] = '{4096, 0, -1000, 9, 0,  4106, -4, -999,  4106, -4, -999,  1'b0, 1'b0};
      vecs[1] = '{1024, 5, -7,    0, 1,  2048, 1029, 1017, 2048, 1029, 1017, 1'b0, 1'b0};
      vecs[2] = '{0, 0, 0,        0, 0,  5120, -2048, 512, 5120, -2048, 512, 1'b0, 1'b0};
      vecs[3] = '{100, 100, 100, 15, 0,  100, 99, 100,    100, 99, 100,    1'b0, 1'b0};
      vecs[4] = '{131000, -131072, 0, 0, 2, 131071, -126976, 4096, -127048, -126976, 4096, 1'b1, 1'b1};
      vecs[5] = '{0, -130000, 0,  0, 0,  5120, -131072, 512, 5120, 130096, 512, 1'b1, 1'b1};

      reset = 1'b1; init_en = 1'b0; step = 1'b0; dt = '0; init_flat = '0; mode = 0;
      tick(); tick();
      chk("reset x", longint'(x_a | x_b), 0);
      chk("reset busy", {busy_a, busy_b}, 0);
      chk("reset done", {done_a, done_b}, 0);
      chk("reset sat", {sat_a, sat_b}, 0);
      chk("reset sel", {sel_a, sel_b}, 0);
      reset = 1'b0;
      tick();
      chk("idle busy", {busy_a, busy_b}, 0);

      for (int v = 0; v < 6; v++) begin
         init_flat = pack(vecs[v].x0, vecs[v].x1, vecs[v].x2);
         init_en = 1'b1;
         tick();
         init_en = 1'b0;
         chk_x($sformatf("v%0d init", v), vecs[v].x0, vecs[v].x1, vecs[v].x2,
               vecs[v].x0, vecs[v].x1, vecs[v].x2);
         chk($sformatf("v%0d init sat", v), {sat_a, sat_b}, 0);
         mode = vecs[v].m;
         dt = 4'(vecs[v].dtv);
         step = 1'b1;
         tick();
         step = 1'b0;
         dt = 4'(vecs[v].dtv) ^ 4'hF;   // must not affect the step in flight
         for (int j = 0; j < C; j++) begin
            chk($sformatf("v%0d sel%0d", v, j), sel_a, j);
            chk($sformatf("v%0d busy%0d", v, j), busy_a, 1);
            chk($sformatf("v%0d early done%0d", v, j), done_a, 0);
            chk_x($sformatf("v%0d hold%0d", v, j), vecs[v].x0, vecs[v].x1, vecs[v].x2,
                  vecs[v].x0, vecs[v].x1, vecs[v].x2);
            tick();
         end
         chk($sformatf("v%0d commit done", v), {done_a, done_b}, 0);
         tick();
         chk($sformatf("v%0d done", v), {done_a, done_b}, 2'b11);
         chk($sformatf("v%0d busy end", v), {busy_a, busy_b}, 0);
         chk_x($sformatf("v%0d result", v), vecs[v].ea0, vecs[v].ea1, vecs[v].ea2,
               vecs[v].eb0, vecs[v].eb1, vecs[v].eb2);
         chk($sformatf("v%0d sat", v), {sat_a, sat_b}, {vecs[v].esat_a, vecs[v].esat_b});
         tick();
         chk($sformatf("v%0d done pulse", v), {done_a, done_b}, 0);
      end

      // init_en clears sticky sat_flag
      init_flat = '0;
      init_en = 1'b1;
      tick();
      init_en = 1'b0;
      chk("init clears sat", {sat_a, sat_b}, 0);

      // step held high: accepts every C+2 cycles, never while busy
      mode = 0; dt = 4'd9; step = 1'b1;
      dones = 0; d_first = -1; d_second = -1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (done_a) begin
            dones++;
            if (d_first < 0) d_first = i;
            else if (d_second < 0) d_second = i;
         end
      end
      step = 1'b0;
      chk("held step dones", dones, 4);
      chk("held step period", d_second - d_first, C + 2);
      chk("held step busy", busy_a, 0);
      chk_x("held step", 40, -16, 4, 40, -16, 4);

      // init_en together with step in IDLE: load only
      init_flat = pack(7, 8, 9);
      init_en = 1'b1; step = 1'b1;
      tick();
      init_en = 1'b0; step = 1'b0;
      chk("init+step busy", busy_a, 0);
      chk_x("init+step", 7, 8, 9, 7, 8, 9);
      tick();
      chk("init+step idle", {busy_a, done_a}, 0);

      // init_en while busy is ignored
      step = 1'b1;
      tick();
      step = 1'b0;
      init_flat = pack(1, 2, 3);
      init_en = 1'b1;
      tick();
      init_en = 1'b0;
      tick(); tick(); tick();
      chk("busy init done", done_a, 1);
      chk_x("busy init", 17, 4, 10, 17, 4, 10);

      // reset in second ACCUM cycle aborts without commit
      step = 1'b1;
      tick();
      step = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("abort busy", {busy_a, busy_b}, 0);
      chk("abort sel", sel_a, 0);
      chk_x("abort", 0, 0, 0, 0, 0, 0);
      dones = 0;
      for (int i = 0; i < 6; i++) begin
         if (done_a || done_b) dones++;
         tick();
      end
      chk("abort no done", dones, 0);
      chk_x("abort after", 0, 0, 0, 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1);
   end
endmodule
